conv_mc_stream: RTL and testbench

- Parametrised successor to the single-channel 3x3 conv1 engine.
- Computes a multi-input-channel, multi-output-channel 2-D valid convolution with configurable stride, per-channel bias, runtime ReLU and requantising shift/saturate.
- Reads pixels, weights and biases from external synchronous memories, one MAC per cycle.
- Streams results out over a valid/ready handshake instead of exposing a whole-plane buffer; sits between the image/weight SRAMs and the next layer.

---
 rtl/conv_mc_stream_if.sv | 35 +++
 rtl/conv_mc_stream.sv | 260 ++++++++++++++++++++++++++
 tb/tb_conv_mc_stream.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_mc_stream_if.sv
// conv_mc_stream result stream bundle.
// Valid/ready handshake plus channel/row/column tags.
interface conv_mc_stream_if #(
  parameter int OUT_W  = 24,
  parameter int OUT_CH = 10,
  parameter int OUT_H  = 14,
  parameter int OUT_WP = 13
);
  localparam int CH_W  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int COL_W = (OUT_WP > 1) ? $clog2(OUT_WP) : 1;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [CH_W-1:0]         out_chan;
  logic [ROW_W-1:0]        out_row;
  logic [COL_W-1:0]        out_col;
  logic                    out_chan_last;
  logic                    out_last;

  modport master (
    output out_valid, out_data, out_chan,
    output out_row, out_col,
    output out_chan_last, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_chan,
    input  out_row, out_col,
    input  out_chan_last, out_last,
    output out_ready
  );
endinterface

// File: rtl/conv_mc_stream.sv
// Multi-channel strided 2-D valid convolution.
// One MAC per cycle from external sync SRAMs, streamed out.
module conv_mc_stream #(
  parameter int K      = 3,
  parameter int IN_H   = 16,
  parameter int IN_W   = 15,
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 10,
  parameter int STRIDE = 1,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 24,
  localparam int OUT_H = (IN_H - K) / STRIDE + 1,
  localparam int OUT_W_PIX = (IN_W - K) / STRIDE + 1,
  localparam int IMG_N = IN_CH * IN_H * IN_W,
  localparam int WT_N  = OUT_CH * IN_CH * K * K,
  localparam int IA_W  = (IMG_N > 1) ? $clog2(IMG_N) : 1,
  localparam int WA_W  = (WT_N > 1) ? $clog2(WT_N) : 1,
  localparam int CH_W  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trigger,
  input  logic            relu_en,
  input  logic [4:0]      shift,
  output logic            busy,
  output logic            done,
  output logic [IA_W-1:0] img_addr,
  input  logic [7:0]      img_rdata,
  output logic [WA_W-1:0] w_addr,
  input  logic [7:0]      w_rdata,
  output logic [CH_W-1:0] b_addr,
  input  logic [15:0]     b_rdata,
  conv_mc_stream_if.master os
);
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int COL_W = (OUT_W_PIX > 1) ? $clog2(OUT_W_PIX) : 1;
  localparam int ICW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] O_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] O_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, BIAS, MAC, DRAIN, OUT, DONE
  } state_t;

  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d;
  logic relu_q, relu_d;
  logic [4:0] shift_q, shift_d;
  logic [ICW-1:0] ic_q, ic_d;
  logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
  logic [CH_W-1:0] oc_q, oc_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [IA_W-1:0] img_addr_q, img_addr_d;
  logic [WA_W-1:0] w_addr_q, w_addr_d;
  logic [CH_W-1:0] b_addr_q, b_addr_d;
  logic out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0] out_chan_q, out_chan_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic out_clast_q, out_clast_d;
  logic out_last_q, out_last_d;

  logic [16:0] pix_x, wt_x;
  logic signed [16:0] prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext;
  logic signed [ACC_W-1:0] acc_sum, relu_v, shv;
  logic tap_first, tap_last, pix_last, run_last;
  logic ovf, unf;

  assign pix_x = {9'd0, img_rdata};
  assign wt_x  = {{9{w_rdata[7]}}, w_rdata};
  assign prod  = $signed(pix_x) * $signed(wt_x);
  assign prod_ext = {{(ACC_W-17){prod[16]}}, prod};
  assign bias_ext = {{(ACC_W-16){b_rdata[15]}}, b_rdata};
  assign acc_sum  = acc_q + prod_ext;

  assign relu_v = (relu_q && acc_sum[ACC_W-1]) ? '0 : acc_sum;
  assign shv = relu_v >>> shift_q;
  assign ovf = shv > SAT_MAX;
  assign unf = shv < SAT_MIN;

  assign tap_first = (ic_q == '0) && (kr_q == '0) && (kc_q == '0);
  assign tap_last = (ic_q == ICW'(IN_CH-1))
                 && (kr_q == KW'(K-1)) && (kc_q == KW'(K-1));
  assign pix_last = (row_q == ROW_W'(OUT_H-1))
                 && (col_q == COL_W'(OUT_W_PIX-1));
  assign run_last = pix_last && (oc_q == CH_W'(OUT_CH-1));

  // Next-state, counter, accumulator and output-register logic
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    done_d = 1'b0;
    relu_d = relu_q;
    shift_d = shift_q;
    ic_d = ic_q;
    kr_d = kr_q;
    kc_d = kc_q;
    oc_d = oc_q;
    row_d = row_q;
    col_d = col_q;
    acc_d = acc_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    out_clast_d = out_clast_q;
    out_last_d = out_last_q;
    unique case (state_q)
      IDLE: if (trigger) begin
        relu_d = relu_en;
        shift_d = shift;
        oc_d = '0;
        row_d = '0;
        col_d = '0;
        busy_d = 1'b1;
        state_d = BIAS;
      end
      BIAS: begin
        ic_d = '0;
        kr_d = '0;
        kc_d = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = tap_first ? bias_ext : acc_sum;
        if (tap_last) begin
          state_d = DRAIN;
        end else if (kc_q != KW'(K-1)) begin
          kc_d = kc_q + KW'(1);
        end else begin
          kc_d = '0;
          if (kr_q != KW'(K-1)) begin
            kr_d = kr_q + KW'(1);
          end else begin
            kr_d = '0;
            ic_d = ic_q + ICW'(1);
          end
        end
      end
      DRAIN: begin
        acc_d = acc_sum;
        out_valid_d = 1'b1;
        out_data_d = ovf ? O_MAX
                   : unf ? O_MIN : shv[OUT_W-1:0];
        out_chan_d = oc_q;
        out_row_d = row_q;
        out_col_d = col_q;
        out_clast_d = pix_last;
        out_last_d = run_last;
        state_d = OUT;
      end
      OUT: if (os.out_ready) begin
        out_valid_d = 1'b0;
        if (col_q != COL_W'(OUT_W_PIX-1)) begin
          col_d = col_q + COL_W'(1);
        end else begin
          col_d = '0;
          if (row_q != ROW_W'(OUT_H-1)) begin
            row_d = row_q + ROW_W'(1);
          end else begin
            row_d = '0;
            oc_d = oc_q + CH_W'(1);
          end
        end
        if (out_last_q) begin
          done_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = BIAS;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    img_addr_d = IA_W'((int'(ic_d) * IN_H
      + int'(row_d) * STRIDE + int'(kr_d)) * IN_W
      + int'(col_d) * STRIDE + int'(kc_d));
    w_addr_d = WA_W'(((int'(oc_d) * IN_CH
      + int'(ic_d)) * K + int'(kr_d)) * K + int'(kc_d));
    b_addr_d = oc_d;
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      relu_q <= 1'b0;
      shift_q <= '0;
      ic_q <= '0;
      kr_q <= '0;
      kc_q <= '0;
      oc_q <= '0;
      row_q <= '0;
      col_q <= '0;
      acc_q <= '0;
      img_addr_q <= '0;
      w_addr_q <= '0;
      b_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      out_clast_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      relu_q <= relu_d;
      shift_q <= shift_d;
      ic_q <= ic_d;
      kr_q <= kr_d;
      kc_q <= kc_d;
      oc_q <= oc_d;
      row_q <= row_d;
      col_q <= col_d;
      acc_q <= acc_d;
      img_addr_q <= img_addr_d;
      w_addr_q <= w_addr_d;
      b_addr_q <= b_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      out_clast_q <= out_clast_d;
      out_last_q <= out_last_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign img_addr = img_addr_q;
  assign w_addr = w_addr_q;
  assign b_addr = b_addr_q;
  assign os.out_valid = out_valid_q;
  assign os.out_data = out_data_q;
  assign os.out_chan = out_chan_q;
  assign os.out_row = out_row_q;
  assign os.out_col = out_col_q;
  assign os.out_chan_last = out_clast_q;
  assign os.out_last = out_last_q;
endmodule

// File: tb/tb_conv_mc_stream.sv
// Bench for conv_mc_stream: default config and a
// 3-channel stride-2 8-bit-output config side by side.
module tb_conv_mc_stream;
  logic clk = 1'b0;
  logic rst, trig, rdy, sel, relu_in;
  logic [4:0] shift_in;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] img_mem [256];
  logic signed [7:0] wt_mem [128];
  logic signed [15:0] b_mem [16];

  conv_mc_stream_if #(.OUT_W(24), .OUT_CH(10),
    .OUT_H(14), .OUT_WP(13)) ifa ();
  conv_mc_stream_if #(.OUT_W(8), .OUT_CH(4),
    .OUT_H(4), .OUT_WP(4)) ifb ();

  logic busy_a, done_a, busy_b, done_b;
  logic [7:0] img_addr_a, img_addr_b;
  logic [6:0] w_addr_a, w_addr_b;
  logic [3:0] b_addr_a;
  logic [1:0] b_addr_b;
  logic [7:0] img_rd_a, img_rd_b, w_rd_a, w_rd_b;
  logic [15:0] b_rd_a, b_rd_b;

  conv_mc_stream u_a (
    .clk(clk), .rst(rst),
    .trigger(trig & ~sel),
    .relu_en(relu_in), .shift(shift_in),
    .busy(busy_a), .done(done_a),
    .img_addr(img_addr_a), .img_rdata(img_rd_a),
    .w_addr(w_addr_a), .w_rdata(w_rd_a),
    .b_addr(b_addr_a), .b_rdata(b_rd_a),
    .os(ifa)
  );

  conv_mc_stream #(
    .IN_H(9), .IN_W(9), .IN_CH(3), .OUT_CH(4),
    .STRIDE(2), .OUT_W(8)
  ) u_b (
    .clk(clk), .rst(rst),
    .trigger(trig & sel),
    .relu_en(relu_in), .shift(shift_in),
    .busy(busy_b), .done(done_b),
    .img_addr(img_addr_b), .img_rdata(img_rd_b),
    .w_addr(w_addr_b), .w_rdata(w_rd_b),
    .b_addr(b_addr_b), .b_rdata(b_rd_b),
    .os(ifb)
  );

  assign ifa.out_ready = rdy & ~sel;
  assign ifb.out_ready = rdy & sel;

  always @(posedge clk) begin
    img_rd_a <= img_mem[img_addr_a];
    img_rd_b <= img_mem[img_addr_b];
    w_rd_a <= wt_mem[w_addr_a];
    w_rd_b <= wt_mem[w_addr_b];
    b_rd_a <= b_mem[b_addr_a];
    b_rd_b <= b_mem[b_addr_b];
  end

  logic o_valid, o_busy, o_done, o_clast, o_last;
  int o_data, o_chan, o_row, o_col;
  assign o_valid = sel ? ifb.out_valid : ifa.out_valid;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_clast = sel ? ifb.out_chan_last
                       : ifa.out_chan_last;
  assign o_last = sel ? ifb.out_last : ifa.out_last;
  assign o_data = sel ? int'(ifb.out_data)
                      : int'(ifa.out_data);
  assign o_chan = sel ? int'(ifb.out_chan)
                      : int'(ifa.out_chan);
  assign o_row = sel ? int'(ifb.out_row)
                     : int'(ifa.out_row);
  assign o_col = sel ? int'(ifb.out_col)
                     : int'(ifa.out_col);

  task automatic chk(input string tag,
                     input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, want);
    end
  endtask

  function automatic int model(
    input int ich, h, wd, st, ow,
    input int relu, sh, oc, r, c);
    longint acc, mx;
    acc = longint'(b_mem[oc]);
    for (int ic = 0; ic < ich; ic++)
      for (int kr = 0; kr < 3; kr++)
        for (int kc = 0; kc < 3; kc++)
          acc += longint'(img_mem[(ic*h + r*st + kr)*wd
                   + c*st + kc])
               * longint'(wt_mem[((oc*ich + ic)*3
                   + kr)*3 + kc]);
    acc = {{40{acc[23]}}, acc[23:0]};
    if (relu != 0 && acc < 0) acc = 0;
    acc = acc >>> sh;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    if (acc > mx) acc = mx;
    if (acc < -mx - 1) acc = -mx - 1;
    return int'(acc);
  endfunction

  task automatic fill_rand(input int pmax, wlo, whi,
                           input int blo, bhi);
    for (int i = 0; i < 256; i++)
      img_mem[i] = 8'($urandom_range(pmax, 0));
    for (int i = 0; i < 128; i++)
      wt_mem[i] = 8'(int'($urandom_range(whi - wlo, 0))
                     + wlo);
    for (int i = 0; i < 16; i++)
      b_mem[i] = 16'(int'($urandom_range(bhi - blo, 0))
                     + blo);
  endtask

  task automatic fill_const(input int p, w, b);
    for (int i = 0; i < 256; i++) img_mem[i] = 8'(p);
    for (int i = 0; i < 128; i++) wt_mem[i] = 8'(w);
    for (int i = 0; i < 16; i++) b_mem[i] = 16'(b);
  endtask

  task automatic run(input bit s,
    input int ich, h, wd, st, och,
    input int relu, sh,
    input bit rnd, stray,
    input int lim, output int first_data);
    int oh, owp, tot, stop, nn, ow;
    int hs, guard, dcnt, vcnt, be;
    int oc, r, c, cl, lst;
    bit pv;
    oh = (h - 3) / st + 1;
    owp = (wd - 3) / st + 1;
    tot = och * oh * owp;
    stop = (lim == 0 || lim > tot) ? tot : lim;
    nn = ich * 9;
    ow = s ? 8 : 24;
    first_data = 0;
    @(negedge clk);
    sel = s;
    relu_in = relu[0];
    shift_in = 5'(sh);
    rdy = 1'b1;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    be = cyc;
    hs = 0;
    guard = 0;
    dcnt = 0;
    pv = 1'b0;
    while (hs < stop && guard < stop*(nn+3)*8 + 50) begin
      if (o_done) dcnt++;
      if (o_valid) begin
        oc = hs / (oh * owp);
        r = (hs / owp) % oh;
        c = hs % owp;
        cl = (r == oh-1 && c == owp-1) ? 1 : 0;
        lst = (cl == 1 && oc == och-1) ? 1 : 0;
        if (!pv) chk("latency", cyc - be, nn + 2);
        chk("data", o_data,
            model(ich, h, wd, st, ow, relu, sh, oc, r, c));
        chk("pos", o_chan*65536 + o_row*256 + o_col,
            oc*65536 + r*256 + c);
        chk("flags", int'(o_clast)*2 + int'(o_last),
            cl*2 + lst);
        if (hs == 0) first_data = o_data;
      end
      pv = o_valid;
      rdy = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      if (o_valid && rdy) begin
        hs++;
        be = cyc + 1;
      end
      trig = stray && guard == 5;
      @(negedge clk);
      guard++;
    end
    trig = 1'b0;
    if (stop < tot) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("early_rst_busy", int'(o_busy), 0);
      chk("early_rst_valid", int'(o_valid), 0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (o_done) begin
          dcnt++;
          trig = stray;
        end else begin
          trig = 1'b0;
        end
        @(negedge clk);
      end
      trig = 1'b0;
      vcnt = 0;
      for (int i = 0; i < nn + 20; i++) begin
        if (o_valid || o_busy) vcnt++;
        @(negedge clk);
      end
      chk("done_count", dcnt, 1);
      chk("idle_after_done", vcnt, 0);
    end
    chk("handshakes", hs, stop);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fd, cnt;
    rst = 1'b1;
    trig = 1'b0;
    rdy = 1'b0;
    sel = 1'b0;
    relu_in = 1'b0;
    shift_in = '0;
    fill_const(0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_valid", int'(ifa.out_valid), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_data", o_data, 0);
    chk("rst_pos", o_chan*65536 + o_row*256 + o_col, 0);
    chk("rst_flags", int'(o_clast)*2 + int'(o_last), 0);
    chk("rst_img_addr", int'(img_addr_a), 0);
    chk("rst_w_addr", int'(w_addr_a), 0);
    chk("rst_b_addr", int'(b_addr_a), 0);
    chk("rst_valid_b", int'(ifb.out_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    fill_rand(255, -128, 127, 0, 0);
    run(0, 1, 16, 15, 1, 10, 1, 0, 0, 0, 0, fd);
    run(0, 1, 16, 15, 1, 10, 1, 0, 1, 1, 0, fd);

    fill_rand(15, -8, 7, -100, 100);
    @(negedge clk);
    sel = 1'b1;
    relu_in = 1'b1;
    shift_in = '0;
    rdy = 1'b1;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("b_busy", int'(o_busy), 1);
    chk("b_bias_addr", int'(b_addr_b), 0);
    @(negedge clk);
    chk("tap0_img", int'(img_addr_b), 0);
    chk("tap0_w", int'(w_addr_b), 0);
    @(negedge clk);
    chk("tap1_img", int'(img_addr_b), 1);
    chk("tap1_w", int'(w_addr_b), 1);
    repeat (2) @(negedge clk);
    chk("tap3_img", int'(img_addr_b), 9);
    chk("tap3_w", int'(w_addr_b), 3);
    repeat (6) @(negedge clk);
    chk("tap9_img", int'(img_addr_b), 81);
    chk("tap9_w", int'(w_addr_b), 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_valid", int'(o_valid), 0);
    cnt = 0;
    repeat (60) begin
      if (o_valid || o_busy) cnt++;
      @(negedge clk);
    end
    chk("mid_rst_quiet", cnt, 0);

    run(1, 3, 9, 9, 2, 4, 0, 4, 1, 1, 0, fd);
    run(1, 3, 9, 9, 2, 4, 1, 2, 0, 0, 0, fd);

    fill_const(255, -128, -1);
    run(0, 1, 16, 15, 1, 10, 0, 0, 0, 0, 1, fd);
    chk("hand_min_24", fd, -293761);
    run(1, 3, 9, 9, 2, 4, 0, 4, 0, 0, 1, fd);
    chk("hand_sat_neg", fd, -128);

    fill_const(0, 0, 1000);
    run(1, 3, 9, 9, 2, 4, 1, 3, 0, 0, 1, fd);
    chk("hand_shift", fd, 125);
    fill_const(0, 0, 2000);
    run(1, 3, 9, 9, 2, 4, 1, 3, 0, 0, 1, fd);
    chk("hand_sat_pos", fd, 127);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
